panda_wb_arbiter: RTL

PANDA_WB_ARBITER -- requirements
Module: panda_wb_arbiter

---
 rtl/panda_wb_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/panda_wb_arbiter.sv
// Two-requester writeback arbiter with register-file output stage and pending-write scoreboard.
// Latency: 1 cycle from accept to rd_we_o/rd_addr_o/rd_data_o; busy bits are read combinationally.
// Backpressure: one ready per cycle, priority only on contention; a losing requester must hold addr/data.
module panda_wb_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [4:0]  req0_addr_i,
    input  logic [31:0] req0_data_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [4:0]  req1_addr_i,
    input  logic [31:0] req1_data_i,

    output logic        rd_we_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,

    input  logic        resv_valid_i,
    input  logic [4:0]  resv_addr_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o
);

    logic        rr_q;
    logic        contended;
    logic        accept;
    logic [4:0]  grant_addr;
    logic [31:0] grant_data;
    logic [31:1] busy_q;
    logic [31:1] busy_set;
    logic [31:1] busy_clr;
    logic [31:0] busy_vec;

    assign contended = !rst_i && req0_valid_i && req1_valid_i;

    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        if (!rst_i) begin
            if (req0_valid_i && req1_valid_i) begin
                req0_ready_o = !rr_q;
                req1_ready_o = rr_q;
            end else begin
                req0_ready_o = req0_valid_i;
                req1_ready_o = req1_valid_i;
            end
        end
    end

    assign accept     = req0_ready_o || req1_ready_o;
    assign grant_addr = req1_ready_o ? req1_addr_i : req0_addr_i;
    assign grant_data = req1_ready_o ? req1_data_i : req0_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q      <= 1'b0;
            rd_we_o   <= 1'b0;
            rd_addr_o <= 5'd0;
            rd_data_o <= 32'd0;
        end else begin
            // Priority passes to the loser of a tie, so it only moves under contention.
            if (contended) begin
                rr_q <= !rr_q;
            end
            rd_we_o <= accept && (grant_addr != 5'd0);
            if (accept) begin
                rd_addr_o <= grant_addr;
                rd_data_o <= grant_data;
            end
        end
    end

    // A register clears when its write reaches the register file; a same-cycle reservation wins.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        for (int i = 1; i < 32; i++) begin
            busy_set[i] = resv_valid_i && (resv_addr_i == 5'(i));
            busy_clr[i] = rd_we_o && (rd_addr_o == 5'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~busy_clr) | busy_set;
        end
    end

    assign busy_vec   = {busy_q, 1'b0};
    assign rs1_busy_o = busy_vec[rs1_addr_i];
    assign rs2_busy_o = busy_vec[rs2_addr_i];

    // Issue stage must not double-reserve; a register committing this cycle is free to re-reserve.
    always @(posedge clk_i) begin
        if (!rst_i && resv_valid_i && (resv_addr_i != 5'd0)) begin
            assert (!busy_vec[resv_addr_i] || (rd_we_o && (rd_addr_o == resv_addr_i)))
                else $error("reservation of already-busy register x%0d", resv_addr_i);
        end
    end

endmodule
